// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int key_code_width(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows, buttons).
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning matrix keypad reader: finds the first pressed key, debounces
// press and release, and reports it as row*COLS+col with a pulse and a held level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS             = 4,
    parameter int COLS             = 4,
    parameter int SCAN_TICKS       = 100_000,
    parameter int DEBOUNCE_SAMPLES = 20
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [ROWS-1:0]                      rows_n,
    output logic [COLS-1:0]                      cols_n,
    output logic [key_code_width(ROWS,COLS)-1:0] key_code,
    output logic                                 key_valid,
    output logic                                 key_held
);

    localparam int KW = key_code_width(ROWS, COLS);
    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam int TW = clog2_min1(SCAN_TICKS);
    localparam int DW = clog2_min1(DEBOUNCE_SAMPLES);

    logic [ROWS-1:0] rows_s;

    scan_state_t   state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          sample_s;
    logic          cnt_done_s;
    logic          row_hit_s;
    logic [RW-1:0] row_idx_s;
    logic [CW-1:0] col_next_s;
    logic [KW-1:0] code_s;

    sync_2ff #(
        .WIDTH     (ROWS),
        .RESET_VAL ({ROWS{1'b1}})
    ) u_rows_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rows_n),
        .q_o     (rows_s)
    );

    assign sample_s   = (tick_q == TW'(SCAN_TICKS - 1));
    assign cnt_done_s = (cnt_q == DW'(DEBOUNCE_SAMPLES - 1));
    assign col_next_s = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    assign code_s     = KW'(row_q) * KW'(COLS) + KW'(col_q);

    // Lowest-index low row wins; scanning downward lets it overwrite higher hits.
    always_comb begin
        row_hit_s = 1'b0;
        row_idx_s = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row_idx_s = (!rows_s[r]) ? RW'(r) : row_idx_s;
            row_hit_s = row_hit_s | ~rows_s[r];
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            tick_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state: decisions are only taken on the sample cycle of each slot.
    always_comb begin
        state_d     = state_q;
        tick_d      = sample_s ? '0 : tick_q + TW'(1);
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (sample_s && row_hit_s) begin
                    row_d   = row_idx_s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else if (sample_s) begin
                    col_d = col_next_s;
                end else begin
                    state_d = SCAN;
                end
            end
            DEBOUNCE: begin
                if (!sample_s) begin
                    state_d = DEBOUNCE;
                end else if (rows_s[row_q]) begin
                    cnt_d   = '0;
                    col_d   = col_next_s;
                    state_d = SCAN;
                end else if (cnt_done_s) begin
                    cnt_d       = '0;
                    key_code_d  = code_s;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!sample_s) begin
                    state_d = HELD;
                end else if (!rows_s[row_q]) begin
                    cnt_d = '0;
                end else if (cnt_done_s) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_d      = col_next_s;
                    state_d    = SCAN;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d    = SCAN;
                col_d      = '0;
                cnt_d      = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    // One-cold column drive decoded from the column register.
    always_comb begin
        cols_n = '1;
        for (int c = 0; c < COLS; c++) begin
            cols_n[c] = (col_q != CW'(c));
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a key-code scoreboard.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] rows_n;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         sb [$];
    int         exp_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS             (4),
        .COLS             (4),
        .SCAN_TICKS       (4),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // A pressed key shorts its row to its column; rows idle high via pull-ups.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows_n[r] = ~|(pressed[r] & ~cols_n);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick(1);
    endtask

    function automatic logic [3:0] col_oh(input int c);
        return ~(4'b0001 << c);
    endfunction

    // Scoreboard: every key_valid pulse must match the next queued key code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(key_valid), 32'd0);
            end else begin
                exp_code = sb.pop_front();
                chk("sb_key_code", 32'(key_code), 32'(exp_code));
                chk("sb_held_with_valid", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cols", 32'(cols_n), 32'h0000_000E);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;

        // Idle scan: each column for four cycles, wrapping after column 3.
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("idle_cols", 32'(cols_n), 32'(col_oh((cyc / 4) % 4)));
            chk("idle_valid", 32'(key_valid), 32'd0);
        end

        // Press row 2 / col 1 -> code 9.
        pressed[2][1] = 1'b1;
        sb.push_back(9);
        run_to(28);
        chk("press_freeze", 32'(cols_n), 32'h0000_000D);
        run_to(35);
        chk("press_early_valid", 32'(key_valid), 32'd0);
        chk("press_early_held", 32'(key_held), 32'd0);
        run_to(36);
        chk("press_valid", 32'(key_valid), 32'd1);
        chk("press_code", 32'(key_code), 32'd9);
        chk("press_held", 32'(key_held), 32'd1);
        pressed[2][1] = 1'b0;
        run_to(37);
        chk("valid_one_cycle", 32'(key_valid), 32'd0);

        // Release with a bounce: high, high, low, then high x3.
        run_to(44);
        chk("rel_held_a", 32'(key_held), 32'd1);
        pressed[2][1] = 1'b1;
        run_to(48);
        chk("rel_held_b", 32'(key_held), 32'd1);
        pressed[2][1] = 1'b0;
        run_to(59);
        chk("rel_held_c", 32'(key_held), 32'd1);
        chk("rel_cols_frozen", 32'(cols_n), 32'h0000_000D);
        run_to(60);
        chk("rel_held_fall", 32'(key_held), 32'd0);
        chk("rel_cols_next", 32'(cols_n), 32'h0000_000B);

        // Press bounce on row 0 / col 3: one low sample only.
        pressed[0][3] = 1'b1;
        run_to(68);
        pressed[0][3] = 1'b0;
        run_to(70);
        chk("bounce_frozen", 32'(cols_n), 32'h0000_0007);
        run_to(72);
        chk("bounce_resume", 32'(cols_n), 32'h0000_000E);
        chk("bounce_code_kept", 32'(key_code), 32'd9);
        chk("bounce_no_valid", 32'(valid_cnt), 32'd1);

        // Rows 1 and 3 in column 2 -> lowest row wins, code 6.
        pressed[1][2] = 1'b1;
        pressed[3][2] = 1'b1;
        sb.push_back(6);
        run_to(96);
        chk("multi_valid", 32'(key_valid), 32'd1);
        chk("multi_code", 32'(key_code), 32'd6);
        run_to(97);
        pressed[0][0] = 1'b1;
        run_to(100);
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
        run_to(111);
        chk("multi_cols_frozen", 32'(cols_n), 32'h0000_000B);
        chk("multi_held", 32'(key_held), 32'd1);
        run_to(112);
        chk("multi_release", 32'(key_held), 32'd0);
        chk("multi_cols_next", 32'(cols_n), 32'h0000_0007);
        chk("multi_valid_count", 32'(valid_cnt), 32'd2);

        // Async reset in the middle of debouncing row 1 / col 1.
        pressed[1][1] = 1'b1;
        run_to(128);
        chk("deb_frozen", 32'(cols_n), 32'h0000_000D);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cols", 32'(cols_n), 32'h0000_000E);
        chk("async_rst_code", 32'(key_code), 32'd0);
        chk("async_rst_valid", 32'(key_valid), 32'd0);
        chk("async_rst_held", 32'(key_held), 32'd0);
        pressed[1][1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        run_to(3);
        chk("restart_col0", 32'(cols_n), 32'h0000_000E);
        run_to(4);
        chk("restart_col1", 32'(cols_n), 32'h0000_000D);
        run_to(8);

        chk("final_valid_count", 32'(valid_cnt), 32'd2);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
